uart_pos_cmd_decoder: RTL and testbench

- Parses the framed byte stream delivered by the async UART receiver into per-channel stepper target positions.
- Raises a one-cycle strobe on each addressed channel.
- Sits between async_receiver and the bank of motorCtrl instances.
- Generalises the earlier inline single-byte "S,chan,pos" parser:
  - parametrised channel count and position width;
  - multi-byte positions;
  - XOR checksum;
  - broadcast addressing;
  - inter-byte timeout;
  - error reporting.

---
 rtl/uart_pos_cmd_decoder_pkg.sv | 20 ++
 rtl/uart_pos_cmd_decoder_cmd_timeout_timer.sv | 35 +++
 rtl/uart_pos_cmd_decoder.sv | 146 ++++++++++++++
 tb/tb_uart_pos_cmd_decoder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pos_cmd_decoder_pkg.sv
// Shared types and defaults for the UART position command decoder.
package uart_pos_cmd_decoder_pkg;

    // Frame parser states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHAN = 2'd1,
        ST_POS  = 2'd2,
        ST_CSUM = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h53;  // "S"
    localparam logic [7:0] BCAST_CH_DEF  = 8'hFF;

    // Number of position bytes carried per frame
    function automatic int unsigned pos_bytes(input int unsigned pos_w);
        return pos_w / 8;
    endfunction

endpackage

// File: rtl/uart_pos_cmd_decoder_cmd_timeout_timer.sv
// Inter-byte timeout: reloads on clear, counts down, pulses expire once at zero.
module cmd_timeout_timer #(
    parameter int unsigned CYC = 2000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (CYC > 2) ? $clog2(CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             expire_q;

    // Expire is flagged in the cycle the count sits at zero, i.e. CYC-1 clocks after a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q    <= LOAD;
            expire_q <= 1'b0;
        end else if (cnt_q != '0) begin
            cnt_q    <= cnt_q - CNT_W'(1);
            expire_q <= (cnt_q == CNT_W'(1));
        end else begin
            expire_q <= 1'b0;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/uart_pos_cmd_decoder.sv
// Parses "SYNC, CH, POS bytes (MSB first), CSUM" frames into per-channel target positions.
module uart_pos_cmd_decoder
    import uart_pos_cmd_decoder_pkg::*;
#(
    parameter int unsigned NUM_CH      = 12,
    parameter int unsigned POS_W       = 24,
    parameter int unsigned TIMEOUT_CYC = 2000,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter logic [7:0]  BCAST_CH    = BCAST_CH_DEF
) (
    input  logic                    CLK_10MHZ,
    input  logic                    RST_N,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic [NUM_CH*POS_W-1:0] pos_out,
    output logic [NUM_CH-1:0]       pos_strobe,
    output logic                    cmd_ok,
    output logic                    cmd_err,
    output logic [7:0]              err_cnt,
    output logic                    busy
);

    localparam int unsigned POS_BYTES = pos_bytes(POS_W);
    localparam int unsigned BCNT_W    = 3;

    state_e                    state_q;
    logic [7:0]                ch_q;
    logic [7:0]                acc_q;
    logic [BCNT_W-1:0]         bcnt_q;
    logic [POS_W-1:0]          shift_q;
    logic [NUM_CH*POS_W-1:0]   pos_q;
    logic [NUM_CH-1:0]         strobe_q;
    logic                      ok_q;
    logic                      err_q;
    logic [7:0]                err_cnt_q;
    logic                      busy_q;

    logic [POS_W-1:0]          shift_d;
    logic                      ch_in_range;
    logic                      frame_good;
    logic                      tmo_clr;
    logic                      tmo_expire;

    // Next shift-register value with the incoming byte appended as the new LSB
    assign shift_d     = POS_W'({shift_q, rx_data});
    assign ch_in_range = (32'(ch_q) < NUM_CH) || (ch_q == BCAST_CH);
    assign frame_good  = (rx_data == acc_q) && ch_in_range;

    // Timer runs only while a frame is open; every received byte restarts it
    assign tmo_clr = rx_valid || (state_q == ST_IDLE);

    cmd_timeout_timer #(
        .CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk     (CLK_10MHZ),
        .rst_n   (RST_N),
        .clr_i   (tmo_clr),
        .expire_o(tmo_expire)
    );

    // Frame parser FSM with registered position, strobe and status outputs
    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            acc_q     <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            pos_q     <= '0;
            strobe_q  <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            strobe_q <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;

            if (tmo_expire && !rx_valid && (state_q != ST_IDLE)) begin
                // Abandon a stalled frame; a coincident byte would have won instead
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end else if (rx_valid) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_q <= ST_CHAN;
                            acc_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_CHAN: begin
                        ch_q    <= rx_data;
                        acc_q   <= rx_data;
                        bcnt_q  <= '0;
                        state_q <= ST_POS;
                    end
                    ST_POS: begin
                        shift_q <= shift_d;
                        acc_q   <= acc_q ^ rx_data;
                        if (bcnt_q == BCNT_W'(POS_BYTES - 1)) begin
                            state_q <= ST_CSUM;
                        end else begin
                            bcnt_q <= bcnt_q + BCNT_W'(1);
                        end
                    end
                    ST_CSUM: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        if (frame_good) begin
                            ok_q <= 1'b1;
                            for (int unsigned k = 0; k < NUM_CH; k++) begin
                                if ((ch_q == BCAST_CH) || (32'(ch_q) == k)) begin
                                    pos_q[k*POS_W +: POS_W] <= shift_q;
                                    strobe_q[k]             <= 1'b1;
                                end
                            end
                        end else begin
                            err_q <= 1'b1;
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_q <= err_cnt_q + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pos_out    = pos_q;
    assign pos_strobe = strobe_q;
    assign cmd_ok     = ok_q;
    assign cmd_err    = err_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_pos_cmd_decoder.sv
// Randomised frame-level checks of uart_pos_cmd_decoder against a behavioural model.
module tb_uart_pos_cmd_decoder;

    localparam int unsigned NCH   = 12;
    localparam int unsigned PW    = 24;
    localparam int unsigned T_CYC = 2000;
    localparam int unsigned NCH_S = 4;
    localparam int unsigned PW_S  = 16;

    logic                clk;
    logic                rst_n;
    logic                rx_valid;
    logic [7:0]          rx_data;
    logic [NCH*PW-1:0]   pos_out;
    logic [NCH-1:0]      pos_strobe;
    logic                cmd_ok;
    logic                cmd_err;
    logic [7:0]          err_cnt;
    logic                busy;

    logic                  rx_valid_s;
    logic [7:0]            rx_data_s;
    logic [NCH_S*PW_S-1:0] pos_out_s;
    logic [NCH_S-1:0]      pos_strobe_s;
    logic                  cmd_ok_s;
    logic                  cmd_err_s;
    logic [7:0]            err_cnt_s;
    logic                  busy_s;

    int n_cmp = 0;
    int n_mis = 0;

    logic [PW-1:0] exp_pos [NCH];
    int            exp_err;
    logic [7:0]    frm [6];

    uart_pos_cmd_decoder #(
        .NUM_CH(NCH), .POS_W(PW), .TIMEOUT_CYC(T_CYC), .SYNC_BYTE(8'h53), .BCAST_CH(8'hFF)
    ) dut (
        .CLK_10MHZ(clk), .RST_N(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .pos_out(pos_out), .pos_strobe(pos_strobe), .cmd_ok(cmd_ok), .cmd_err(cmd_err),
        .err_cnt(err_cnt), .busy(busy)
    );

    uart_pos_cmd_decoder #(
        .NUM_CH(NCH_S), .POS_W(PW_S), .TIMEOUT_CYC(50), .SYNC_BYTE(8'h53), .BCAST_CH(8'hFF)
    ) dut_s (
        .CLK_10MHZ(clk), .RST_N(rst_n), .rx_valid(rx_valid_s), .rx_data(rx_data_s),
        .pos_out(pos_out_s), .pos_strobe(pos_strobe_s), .cmd_ok(cmd_ok_s), .cmd_err(cmd_err_s),
        .err_cnt(err_cnt_s), .busy(busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte, consumed by the DUT at the second posedge; returns 1 time unit after it
    task automatic send_byte(input bit sel, input logic [7:0] b);
        @(posedge clk);
        #1;
        if (sel) begin
            rx_valid_s = 1'b1;
            rx_data_s  = b;
        end else begin
            rx_valid = 1'b1;
            rx_data  = b;
        end
        @(posedge clk);
        #1;
        rx_valid   = 1'b0;
        rx_valid_s = 1'b0;
    endtask

    task automatic gap();
        repeat (9) @(posedge clk);
    endtask

    task automatic load_frame(input logic [7:0] ch, input logic [PW-1:0] p, input logic [7:0] cs);
        frm = '{8'h53, ch, p[23:16], p[15:8], p[7:0], cs};
    endtask

    function automatic logic [7:0] csum_of(input logic [7:0] ch, input logic [PW-1:0] p);
        return ch ^ p[23:16] ^ p[15:8] ^ p[7:0];
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_errcnt"}, 32'(err_cnt), 32'(exp_err));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        for (int k = 0; k < NCH; k++) begin
            chk({tag, "_pos"}, 32'(pos_out[k*PW +: PW]), 32'(exp_pos[k]));
        end
    endtask

    // Send frm[first..5], then compare against the model one clock after the checksum byte
    task automatic run_frame(input int first, input string tag);
        logic          good;
        logic [7:0]    ch;
        logic [PW-1:0] p;
        logic [NCH-1:0] exp_strb;
        for (int i = first; i < 5; i++) begin
            send_byte(1'b0, frm[i]);
            gap();
        end
        send_byte(1'b0, frm[5]);
        ch   = frm[1];
        p    = {frm[2], frm[3], frm[4]};
        good = (frm[5] == (frm[1] ^ frm[2] ^ frm[3] ^ frm[4])) && ((ch < NCH) || (ch == 8'hFF));
        exp_strb = '0;
        if (good) begin
            for (int k = 0; k < NCH; k++) begin
                if ((ch == 8'hFF) || (int'(ch) == k)) begin
                    exp_strb[k] = 1'b1;
                    exp_pos[k]  = p;
                end
            end
        end else begin
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
        chk({tag, "_ok"}, 32'(cmd_ok), 32'(good));
        chk({tag, "_err"}, 32'(cmd_err), 32'(!good));
        chk({tag, "_strobe"}, 32'(pos_strobe), 32'(exp_strb));
        check_state(tag);
        @(posedge clk);
        #1;
        chk({tag, "_ok_end"}, 32'(cmd_ok), 32'd0);
        chk({tag, "_err_end"}, 32'(cmd_err), 32'd0);
        chk({tag, "_strobe_end"}, 32'(pos_strobe), 32'd0);
        repeat (8) @(posedge clk);
    endtask

    initial begin
        int            lat;
        logic [7:0]    ch;
        logic [7:0]    cs;
        logic [7:0]    g;
        logic [PW-1:0] p;

        rst_n      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = '0;
        rx_valid_s = 1'b0;
        rx_data_s  = '0;
        exp_err    = 0;
        for (int k = 0; k < NCH; k++) exp_pos[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ok", 32'(cmd_ok), 32'd0);
        chk("rst_err", 32'(cmd_err), 32'd0);
        chk("rst_strobe", 32'(pos_strobe), 32'd0);
        check_state("rst");
        rst_n = 1'b1;
        gap();

        // Single channel, broadcast, bad checksum, out-of-range channel
        load_frame(8'h03, 24'h001234, csum_of(8'h03, 24'h001234));
        run_frame(0, "ch3");
        load_frame(8'hFF, 24'h000010, 8'hEF);
        run_frame(0, "bcast");
        load_frame(8'h02, 24'h000005, 8'h00);
        run_frame(0, "badcs");
        load_frame(8'h0C, 24'h000001, 8'h0D);
        run_frame(0, "badch");

        // Stalled frame times out exactly TIMEOUT_CYC clocks after the last byte
        load_frame(8'h05, 24'h000007, 8'h02);
        send_byte(1'b0, frm[0]);
        gap();
        send_byte(1'b0, frm[1]);
        gap();
        send_byte(1'b0, frm[2]);
        chk("tmo_busy_open", 32'(busy), 32'd1);
        lat = -1;
        for (int i = 1; i <= int'(T_CYC) + 10; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                lat = i;
                break;
            end
        end
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        chk("tmo_latency", 32'(lat), 32'(T_CYC));
        chk("tmo_err", 32'(cmd_err), 32'd1);
        chk("tmo_errcnt", 32'(err_cnt), 32'(exp_err));
        @(posedge clk);
        #1;
        chk("tmo_err_end", 32'(cmd_err), 32'd0);
        repeat (8) @(posedge clk);
        run_frame(0, "after_tmo");

        // A byte arriving in the expiry cycle keeps the frame alive
        load_frame(8'h09, 24'h0A0B0C, csum_of(8'h09, 24'h0A0B0C));
        send_byte(1'b0, frm[0]);
        gap();
        send_byte(1'b0, frm[1]);
        repeat (T_CYC - 2) @(posedge clk);
        send_byte(1'b0, frm[2]);
        chk("edge_busy", 32'(busy), 32'd1);
        chk("edge_err", 32'(cmd_err), 32'd0);
        gap();
        run_frame(3, "edge");

        // Garbage outside a frame is silently dropped
        foreach (frm[i]) frm[i] = 8'h00;
        send_byte(1'b0, 8'h41);
        gap();
        send_byte(1'b0, 8'h00);
        gap();
        send_byte(1'b0, 8'h7F);
        chk("garbage_err", 32'(cmd_err), 32'd0);
        check_state("garbage");
        gap();
        load_frame(8'h07, 24'h00BEEF, csum_of(8'h07, 24'h00BEEF));
        run_frame(0, "post_garbage");

        // Sync character inside the payload is plain data
        load_frame(8'h04, 24'h535353, csum_of(8'h04, 24'h535353));
        run_frame(0, "sync_data");

        // Random mix of good, corrupted, broadcast and out-of-range frames
        for (int n = 0; n < 60; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7)       ch = 8'($urandom_range(0, NCH - 1));
            else if (r == 7) ch = 8'hFF;
            else             ch = 8'($urandom_range(NCH, 254));
            p  = PW'($urandom);
            cs = csum_of(ch, p);
            if ($urandom_range(0, 4) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom);
                if (g == 8'h53) g = 8'h54;
                send_byte(1'b0, g);
                chk("rnd_garbage_busy", 32'(busy), 32'd0);
                gap();
            end
            load_frame(ch, p, cs);
            run_frame(0, "rnd");
        end

        // Error counter saturation
        for (int n = 0; n < 300; n++) begin
            p = PW'($urandom);
            ch = 8'($urandom_range(0, NCH - 1));
            load_frame(ch, p, csum_of(ch, p) ^ 8'h5A);
            run_frame(0, "sat");
        end
        chk("sat_final", 32'(err_cnt), 32'd255);

        // Reset in the middle of a frame
        load_frame(8'h03, 24'h000111, csum_of(8'h03, 24'h000111));
        send_byte(1'b0, frm[0]);
        gap();
        send_byte(1'b0, frm[1]);
        gap();
        send_byte(1'b0, frm[2]);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        exp_err = 0;
        for (int k = 0; k < NCH; k++) exp_pos[k] = '0;
        chk("midrst_ok", 32'(cmd_ok), 32'd0);
        chk("midrst_err", 32'(cmd_err), 32'd0);
        chk("midrst_strobe", 32'(pos_strobe), 32'd0);
        check_state("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        gap();
        load_frame(8'h0B, 24'hFEDCBA, csum_of(8'h0B, 24'hFEDCBA));
        run_frame(0, "post_rst");

        // Narrower instance: 4 channels, 16-bit positions
        send_byte(1'b1, 8'h53);
        gap();
        send_byte(1'b1, 8'h01);
        gap();
        send_byte(1'b1, 8'hAB);
        gap();
        send_byte(1'b1, 8'hCD);
        gap();
        send_byte(1'b1, 8'h67);
        chk("sweep_pos1", 32'(pos_out_s[16 +: 16]), 32'h0000ABCD);
        chk("sweep_pos0", 32'(pos_out_s[0 +: 16]), 32'd0);
        chk("sweep_pos23", 32'(pos_out_s[63:32]), 32'd0);
        chk("sweep_strobe", 32'(pos_strobe_s), 32'h2);
        chk("sweep_ok", 32'(cmd_ok_s), 32'd1);
        chk("sweep_err", 32'(cmd_err_s), 32'd0);
        @(posedge clk);
        #1;
        chk("sweep_ok_end", 32'(cmd_ok_s), 32'd0);
        chk("sweep_busy", 32'(busy_s), 32'd0);
        chk("sweep_errcnt", 32'(err_cnt_s), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
